// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock datapath counters.
package clock_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_MIN = 4'd0;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] int_to_bcd(input int unsigned val,
                                                               input int unsigned digits);
        logic [BCD_W*MAX_DIGITS-1:0] res;
        int unsigned                 v;
        res = '0;
        v   = val;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                res[BCD_W*i +: BCD_W] = BCD_W'(v % 10);
                v = v / 10;
            end
        end
        return res;
    endfunction

    function automatic logic bcd_valid(input logic [BCD_W*MAX_DIGITS-1:0] vec);
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (vec[BCD_W*i +: BCD_W] > DIGIT_MAX) return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/bcd_range_counter_if.sv
// Control/status bundle of one BCD range counter; master drives, counter is slave.
interface bcd_range_counter_if #(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned W = 4 * DIGITS;

    logic         i_clr;
    logic         i_load;
    logic [W-1:0] i_din;
    logic         i_ena;
    logic         i_inc;
    logic [W-1:0] o_q;
    logic         o_carry;
    logic         o_roll;
    logic         o_err;

    modport master (
        output i_clr, i_load, i_din, i_ena, i_inc,
        input  o_q, o_carry, o_roll, o_err
    );

    modport slave (
        input  i_clr, i_load, i_din, i_ena, i_inc,
        output o_q, o_carry, o_roll, o_err
    );

endinterface

// File: rtl/bcd_range_counter_digit.sv
// One BCD digit register: force (clear/load/wrap) overrides a 0..9 up/down step.
module bcd_digit
    import clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] RST_DIGIT = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_inc,
    input  logic             i_step,
    input  logic             i_force,
    input  logic [BCD_W-1:0] i_force_val,
    output logic [BCD_W-1:0] o_d,
    output logic             o_carry_up,
    output logic             o_borrow_dn
);

    logic [BCD_W-1:0] d_q;
    logic [BCD_W-1:0] d_d;

    always_comb begin
        d_d = d_q;
        if (i_force) begin
            d_d = i_force_val;
        end else if (i_step) begin
            if (i_inc) d_d = (d_q == DIGIT_MAX) ? DIGIT_MIN : d_q + 4'd1;
            else       d_d = (d_q == DIGIT_MIN) ? DIGIT_MAX : d_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) d_q <= RST_DIGIT;
        else            d_q <= d_d;
    end

    assign o_d         = d_q;
    assign o_carry_up  = (d_q == DIGIT_MAX);
    assign o_borrow_dn = (d_q == DIGIT_MIN);

endmodule

// File: rtl/bcd_range_counter.sv
// Packed-BCD up/down counter over MIN_VAL..MAX_VAL with chainable same-cycle carry,
// range-checked load, synchronous clear and roll/error pulses.
module bcd_range_counter
    import clock_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 59,
    parameter int unsigned RST_VAL = 0
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    bcd_range_counter_if.slave  bus
);

    localparam int unsigned W = BCD_W * DIGITS;

    if (DIGITS < 1 || DIGITS > MAX_DIGITS || MIN_VAL >= MAX_VAL ||
        MAX_VAL >= 10**DIGITS || RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_param_check
        $fatal(1, "bcd_range_counter: illegal DIGITS/MIN_VAL/MAX_VAL/RST_VAL combination");
    end

    localparam logic [W-1:0] MIN_BCD = W'(int_to_bcd(MIN_VAL, DIGITS));
    localparam logic [W-1:0] MAX_BCD = W'(int_to_bcd(MAX_VAL, DIGITS));
    localparam logic [W-1:0] RST_BCD = W'(int_to_bcd(RST_VAL, DIGITS));

    logic              step;
    logic              wrap;
    logic              load_ok;
    logic              force_en;
    logic [W-1:0]      force_val;
    logic [W-1:0]      q;
    logic [DIGITS-1:0] cy_up;
    logic [DIGITS-1:0] bw_dn;
    logic              roll_q, roll_d;
    logic              err_q, err_d;

    // Valid packed BCD orders the same as its binary value, so range checks compare vectors directly.
    always_comb begin
        load_ok   = bcd_valid((BCD_W*MAX_DIGITS)'(bus.i_din)) &&
                    (bus.i_din >= MIN_BCD) && (bus.i_din <= MAX_BCD);
        step      = bus.i_ena & ~bus.i_clr & ~bus.i_load;
        wrap      = step & (bus.i_inc ? (q == MAX_BCD) : (q == MIN_BCD));
        force_en  = 1'b0;
        force_val = RST_BCD;
        if (bus.i_clr) begin
            force_en  = 1'b1;
            force_val = RST_BCD;
        end else if (bus.i_load) begin
            force_en  = load_ok;
            force_val = bus.i_din;
        end else if (wrap) begin
            force_en  = 1'b1;
            force_val = bus.i_inc ? MIN_BCD : MAX_BCD;
        end
        roll_d = wrap;
        err_d  = bus.i_load & ~bus.i_clr & ~load_ok;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic             dstep;
        logic [BCD_W-1:0] d_w;

        // A digit steps only when every lower digit is at its carry/borrow point.
        if (i == 0) begin : g_lsd
            assign dstep = step;
        end else begin : g_upper
            assign dstep = step & (bus.i_inc ? &cy_up[i-1:0] : &bw_dn[i-1:0]);
        end

        bcd_digit #(
            .RST_DIGIT (RST_BCD[BCD_W*i +: BCD_W])
        ) u_digit (
            .i_clk       (i_clk),
            .i_reset_n   (i_reset_n),
            .i_inc       (bus.i_inc),
            .i_step      (dstep),
            .i_force     (force_en),
            .i_force_val (force_val[BCD_W*i +: BCD_W]),
            .o_d         (d_w),
            .o_carry_up  (cy_up[i]),
            .o_borrow_dn (bw_dn[i])
        );

        assign q[BCD_W*i +: BCD_W] = d_w;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            roll_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            roll_q <= roll_d;
            err_q  <= err_d;
        end
    end

    assign bus.o_q     = q;
    assign bus.o_carry = wrap;
    assign bus.o_roll  = roll_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_bcd_range_counter.sv
// Bench for bcd_range_counter: 12h instance plus a chained 0..59 -> 0..23 pair,
// checked every cycle against an integer-valued reference model.
module tb_bcd_range_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_range_counter_if #(.DIGITS(2)) h12_if ();
    bcd_range_counter_if #(.DIGITS(2)) sec_if ();
    bcd_range_counter_if #(.DIGITS(2)) hr_if  ();

    assign hr_if.i_ena = sec_if.o_carry;

    bcd_range_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12), .RST_VAL(12)) u_h12 (
        .i_clk (clk), .i_reset_n (rst_n), .bus (h12_if));
    bcd_range_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .RST_VAL(0)) u_sec (
        .i_clk (clk), .i_reset_n (rst_n), .bus (sec_if));
    bcd_range_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(23), .RST_VAL(0)) u_hr (
        .i_clk (clk), .i_reset_n (rst_n), .bus (hr_if));

    typedef struct {
        int v;
        bit roll;
        bit err;
    } mstate_t;

    mstate_t m12, msec, mhr;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit carry_of(input mstate_t s, input int mn, input int mx,
                                    input bit clr, input bit load, input bit ena, input bit inc);
        return ena && !clr && !load && (inc ? (s.v == mx) : (s.v == mn));
    endfunction

    function automatic mstate_t next_of(input mstate_t s, input int mn, input int mx, input int rs,
                                        input bit clr, input bit load, input logic [7:0] din,
                                        input bit ena, input bit inc);
        mstate_t n;
        int hi, lo, val;
        n = s;
        n.roll = 1'b0;
        n.err  = 1'b0;
        hi  = int'(din[7:4]);
        lo  = int'(din[3:0]);
        val = hi * 10 + lo;
        if (clr) begin
            n.v = rs;
        end else if (load) begin
            if (hi <= 9 && lo <= 9 && val >= mn && val <= mx) n.v = val;
            else n.err = 1'b1;
        end else if (ena) begin
            if (inc) begin
                if (s.v == mx) begin n.v = mn; n.roll = 1'b1; end
                else n.v = s.v + 1;
            end else begin
                if (s.v == mn) begin n.v = mx; n.roll = 1'b1; end
                else n.v = s.v - 1;
            end
        end
        return n;
    endfunction

    task automatic check_inst(input string name, input mstate_t s,
                              input logic [7:0] q, input logic roll, input logic err);
        chk({name, ".q"},    {24'd0, q},    {24'd0, to_bcd(s.v)});
        chk({name, ".roll"}, {31'd0, roll}, {31'd0, s.roll});
        chk({name, ".err"},  {31'd0, err},  {31'd0, s.err});
    endtask

    task automatic model_reset();
        m12  = '{v: 12, roll: 1'b0, err: 1'b0};
        msec = '{v: 0,  roll: 1'b0, err: 1'b0};
        mhr  = '{v: 0,  roll: 1'b0, err: 1'b0};
    endtask

    task automatic check_all();
        check_inst("h12", m12,  h12_if.o_q, h12_if.o_roll, h12_if.o_err);
        check_inst("sec", msec, sec_if.o_q, sec_if.o_roll, sec_if.o_err);
        check_inst("hr",  mhr,  hr_if.o_q,  hr_if.o_roll,  hr_if.o_err);
    endtask

    // Inputs are set by the caller shortly after an edge; carries are checked mid-cycle.
    task automatic tick();
        bit c12, cs, ch;
        #2;
        c12 = carry_of(m12, 1, 12, h12_if.i_clr, h12_if.i_load, h12_if.i_ena, h12_if.i_inc);
        cs  = carry_of(msec, 0, 59, sec_if.i_clr, sec_if.i_load, sec_if.i_ena, sec_if.i_inc);
        ch  = carry_of(mhr, 0, 23, hr_if.i_clr, hr_if.i_load, cs, hr_if.i_inc);
        chk("h12.carry", {31'd0, h12_if.o_carry}, {31'd0, c12});
        chk("sec.carry", {31'd0, sec_if.o_carry}, {31'd0, cs});
        chk("hr.carry",  {31'd0, hr_if.o_carry},  {31'd0, ch});
        @(posedge clk);
        #1;
        m12  = next_of(m12, 1, 12, 12, h12_if.i_clr, h12_if.i_load, h12_if.i_din,
                       h12_if.i_ena, h12_if.i_inc);
        msec = next_of(msec, 0, 59, 0, sec_if.i_clr, sec_if.i_load, sec_if.i_din,
                       sec_if.i_ena, sec_if.i_inc);
        mhr  = next_of(mhr, 0, 23, 0, hr_if.i_clr, hr_if.i_load, hr_if.i_din, cs, hr_if.i_inc);
        check_all();
    endtask

    task automatic set_idle();
        h12_if.i_clr = 1'b0; h12_if.i_load = 1'b0; h12_if.i_din = '0; h12_if.i_ena = 1'b0; h12_if.i_inc = 1'b1;
        sec_if.i_clr = 1'b0; sec_if.i_load = 1'b0; sec_if.i_din = '0; sec_if.i_ena = 1'b0; sec_if.i_inc = 1'b1;
        hr_if.i_clr  = 1'b0; hr_if.i_load  = 1'b0; hr_if.i_din  = '0; hr_if.i_inc  = 1'b1;
    endtask

    function automatic logic [7:0] rand_din();
        case ($urandom_range(0, 3))
            0:       return 8'($urandom);
            1:       return 8'h59;
            default: return to_bcd(int'($urandom_range(0, 99)));
        endcase
    endfunction

    initial begin
        set_idle();
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;

        // 12h up from reset: 12 -> 01 ... 12 -> 01
        h12_if.i_ena = 1'b1;
        h12_if.i_inc = 1'b1;
        repeat (13) tick();
        chk("h12.up_end", {24'd0, h12_if.o_q}, 32'h01);

        // 12h down from 01: 01 -> 12 -> 11 -> 10 -> 09
        h12_if.i_inc = 1'b0;
        repeat (4) tick();
        chk("h12.down_end", {24'd0, h12_if.o_q}, 32'h09);
        h12_if.i_ena = 1'b0;

        // Loads on 0..59
        sec_if.i_load = 1'b1;
        sec_if.i_din = 8'h45; tick();
        sec_if.i_din = 8'h60; tick();
        sec_if.i_din = 8'h3A; tick();
        sec_if.i_din = 8'h12; sec_if.i_ena = 1'b1; tick();
        sec_if.i_load = 1'b0; sec_if.i_ena = 1'b0; tick();

        // Chained wrap: 59/23 -> 00/00 on one edge
        sec_if.i_load = 1'b1; sec_if.i_din = 8'h59;
        hr_if.i_load  = 1'b1; hr_if.i_din  = 8'h23;
        tick();
        sec_if.i_load = 1'b0; hr_if.i_load = 1'b0;
        sec_if.i_ena = 1'b1; sec_if.i_inc = 1'b1; hr_if.i_inc = 1'b1;
        tick();
        chk("chain.both_roll", {31'd0, sec_if.o_roll & hr_if.o_roll}, 32'd1);
        sec_if.i_ena = 1'b0;
        tick();

        // Clear beats load beats step
        h12_if.i_clr = 1'b1; h12_if.i_load = 1'b1; h12_if.i_din = 8'h05; h12_if.i_ena = 1'b1;
        sec_if.i_clr = 1'b1; sec_if.i_load = 1'b1; sec_if.i_din = 8'h33; sec_if.i_ena = 1'b1;
        hr_if.i_clr  = 1'b1; hr_if.i_load  = 1'b1; hr_if.i_din  = 8'h07;
        tick();
        set_idle();
        tick();

        // Randomised operation on all three counters
        repeat (600) begin
            h12_if.i_clr  = ($urandom_range(0, 39) == 0);
            h12_if.i_load = ($urandom_range(0, 7) == 0);
            h12_if.i_din  = rand_din();
            h12_if.i_ena  = ($urandom_range(0, 3) != 0);
            h12_if.i_inc  = 1'($urandom_range(0, 1));
            sec_if.i_clr  = ($urandom_range(0, 39) == 0);
            sec_if.i_load = ($urandom_range(0, 7) == 0);
            sec_if.i_din  = rand_din();
            sec_if.i_ena  = ($urandom_range(0, 3) != 0);
            sec_if.i_inc  = 1'($urandom_range(0, 1));
            hr_if.i_clr   = ($urandom_range(0, 39) == 0);
            hr_if.i_load  = ($urandom_range(0, 9) == 0);
            hr_if.i_din   = rand_din();
            hr_if.i_inc   = 1'($urandom_range(0, 1));
            tick();
        end

        // Async reset mid-count with a roll pulse pending
        set_idle();
        h12_if.i_load = 1'b1; h12_if.i_din = 8'h12;
        tick();
        h12_if.i_load = 1'b0; h12_if.i_ena = 1'b1; h12_if.i_inc = 1'b1;
        tick();
        chk("rst.pre_roll", {31'd0, h12_if.o_roll}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.async_q",    {24'd0, h12_if.o_q}, 32'h12);
        chk("rst.async_roll", {31'd0, h12_if.o_roll}, 32'd0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst.resume", {24'd0, h12_if.o_q}, 32'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
